// File: rtl/excess3_pkg.sv
// Shared constants, state encoding and code-range helper for the Excess-3 to BCD decoder.
// Imported by the digit decoder, the interface and the top level.
package excess3_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] X3_OFFSET = 4'd3;
    localparam logic [DIGIT_W-1:0] X3_MIN    = 4'b0011;
    localparam logic [DIGIT_W-1:0] X3_MAX    = 4'b1100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    function automatic logic x3_is_valid(input logic [DIGIT_W-1:0] code);
        return (code >= X3_MIN) && (code <= X3_MAX);
    endfunction

endpackage

// File: rtl/excess3_bcd_decoder_if.sv
// Digit-in / word-out bus of the Excess-3 decoder.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1;
// valid never waits for ready, and the payload stays stable while valid=1 and ready=0.
interface excess3_bcd_decoder_if #(
    parameter int NDIG = 4
);
    import excess3_pkg::*;

    logic                      in_valid;
    logic [DIGIT_W-1:0]        in_digit;
    logic                      in_last;
    logic                      in_ready;

    logic                      out_valid;
    logic                      out_ready;
    logic [DIGIT_W*NDIG-1:0]   out_bcd;
    logic                      out_err;
    logic [NDIG-1:0]           out_err_mask;
    logic [3:0]                out_count;

    modport slave (
        input  in_valid,
        input  in_digit,
        input  in_last,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_bcd,
        output out_err,
        output out_err_mask,
        output out_count
    );

    modport master (
        output in_valid,
        output in_digit,
        output in_last,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_bcd,
        input  out_err,
        input  out_err_mask,
        input  out_count
    );

endinterface

// File: rtl/x3_digit_dec.sv
// Combinational single-digit Excess-3 to BCD decoder.
// Codes outside 0011..1100 decode to 0 and raise invalid.
module x3_digit_dec
    import excess3_pkg::*;
(
    input  logic [DIGIT_W-1:0] code,
    output logic [DIGIT_W-1:0] bcd,
    output logic               invalid
);

    always_comb begin
        invalid = !x3_is_valid(code);
        bcd     = '0;
        if (!invalid) begin
            bcd = code - X3_OFFSET;
        end
    end

endmodule

// File: rtl/excess3_bcd_decoder.sv
// Assembles up to NDIG Excess-3 digits (MSD first) into a packed BCD word with a per-digit error mask.
// The word is held until the consumer takes it; no digit is accepted while a word is held.
module excess3_bcd_decoder
    import excess3_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    excess3_bcd_decoder_if.slave   bus,
    output state_t                 state_dbg
);

    localparam int WORD_W = DIGIT_W * NDIG;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [NDIG-1:0]     mask_q, mask_d;
    logic [3:0]          count_q, count_d;

    logic [DIGIT_W-1:0]  dig_bcd;
    logic                dig_inv;
    logic                accept;
    logic                word_done;

    x3_digit_dec u_dec (
        .code    (bus.in_digit),
        .bcd     (dig_bcd),
        .invalid (dig_inv)
    );

    assign accept    = bus.in_valid && (state_q != HOLD);
    // The word closes either on an explicit in_last or when this digit fills the last slot.
    assign word_done = bus.in_last || ((count_q + 4'd1) == 4'(NDIG));

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        mask_d  = mask_q;
        count_d = count_q;
        case (state_q)
            IDLE, COLLECT: begin
                if (accept) begin
                    word_d  = (word_q << DIGIT_W) | WORD_W'(dig_bcd);
                    mask_d  = (mask_q << 1) | NDIG'(dig_inv);
                    count_d = count_q + 4'd1;
                    state_d = word_done ? HOLD : COLLECT;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    word_d  = '0;
                    mask_d  = '0;
                    count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                word_d  = '0;
                mask_d  = '0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            mask_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            mask_q  <= mask_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready     = (state_q != HOLD);
    assign bus.out_valid    = (state_q == HOLD);
    assign bus.out_bcd      = word_q;
    assign bus.out_err_mask = mask_q;
    assign bus.out_err      = |mask_q;
    assign bus.out_count    = count_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_excess3_bcd_decoder.sv
// Self-checking bench for excess3_bcd_decoder: directed word cases, code sweep and random words
// with random backpressure, checked against a scoreboard of independently modelled words.
module tb_excess3_bcd_decoder;
    import excess3_pkg::*;

    localparam int NDIG   = 4;
    localparam int WORD_W = 4 * NDIG;
    localparam int PW     = 1 + 4 + NDIG + WORD_W;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t state_dbg;
    bit     bp_mode = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [PW-1:0] exp_q[$];

    always #5 clk = ~clk;

    excess3_bcd_decoder_if #(.NDIG(NDIG)) bus ();

    excess3_bcd_decoder #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [PW-1:0] pack_word(input logic err, input logic [3:0] cnt,
                                                input logic [NDIG-1:0] mask,
                                                input logic [WORD_W-1:0] bcd);
        return {err, cnt, mask, bcd};
    endfunction

    // Reference: plain arithmetic on each code, MSD first, right-justified.
    function automatic logic [PW-1:0] model_word(input logic [3:0] codes[NDIG], input int n);
        logic [WORD_W-1:0] bcd = '0;
        logic [NDIG-1:0]   mask = '0;
        for (int i = 0; i < n; i++) begin
            if (codes[i] >= 4'd3 && codes[i] <= 4'd12) begin
                bcd  = {bcd[WORD_W-5:0], 4'(codes[i] - 4'd3)};
                mask = {mask[NDIG-2:0], 1'b0};
            end else begin
                bcd  = {bcd[WORD_W-5:0], 4'b0000};
                mask = {mask[NDIG-2:0], 1'b1};
            end
        end
        return pack_word(|mask, 4'(n), mask, bcd);
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_word", 64'(exp_q.size()), 64'd1);
            end else begin
                check_eq("word", 64'(pack_word(bus.out_err, bus.out_count, bus.out_err_mask, bus.out_bcd)),
                         64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_digit(input logic [3:0] code, input logic last);
        bit rdy;
        int budget = 0;
        bus.in_valid = 1'b1;
        bus.in_digit = code;
        bus.in_last  = last;
        do begin
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            budget++;
        end while (!rdy && budget < 60);
        if (!rdy) check_eq("accept_timeout", 64'(rdy), 64'd1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_digit = 4'($urandom_range(0, 15));
    endtask

    task automatic send_word(input logic [3:0] codes[NDIG], input int n, input bit use_last);
        exp_q.push_back(model_word(codes, n));
        for (int i = 0; i < n; i++) send_digit(codes[i], use_last && (i == n - 1));
    endtask

    task automatic wait_drain();
        int budget = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (budget >= 200) check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [3:0]        codes[NDIG];
        logic [WORD_W-1:0] snap_bcd;
        logic [NDIG-1:0]   snap_mask;
        logic [3:0]        snap_cnt;
        int                len;

        bus.in_valid  = 1'b0;
        bus.in_digit  = 4'd0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_out_bcd", 64'(bus.out_bcd), 64'd0);
        check_eq("rst_out_count", 64'(bus.out_count), 64'd0);
        check_eq("rst_out_err", 64'({bus.out_err, bus.out_err_mask}), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst_state", 64'(state_dbg), 64'(IDLE));

        // Full word, back-to-back, with latency check on the last digit
        codes = '{4'b0100, 4'b0111, 4'b1010, 4'b1100};
        exp_q.push_back(model_word(codes, 4));
        for (int i = 0; i < 3; i++) send_digit(codes[i], 1'b0);
        check_eq("full_not_yet_valid", 64'(bus.out_valid), 64'd0);
        send_digit(codes[3], 1'b0);
        check_eq("full_valid_lat1", 64'(bus.out_valid), 64'd1);
        check_eq("full_bcd", 64'(bus.out_bcd), 64'h1479);
        check_eq("full_err", 64'(bus.out_err), 64'd0);
        check_eq("full_count", 64'(bus.out_count), 64'd4);
        check_eq("hold_in_ready", 64'(bus.in_ready), 64'd0);
        wait_drain();

        // Short word
        codes = '{4'b1000, 4'b0011, 4'b0000, 4'b0000};
        send_word(codes, 2, 1'b1);
        check_eq("short_bcd", 64'(bus.out_bcd), 64'h0050);
        check_eq("short_count", 64'(bus.out_count), 64'd2);
        wait_drain();

        // Invalid code in the middle
        codes = '{4'b0011, 4'b1111, 4'b0101, 4'b1100};
        send_word(codes, 4, 1'b0);
        check_eq("inv_bcd", 64'(bus.out_bcd), 64'h0029);
        check_eq("inv_mask", 64'(bus.out_err_mask), 64'b0100);
        check_eq("inv_err", 64'(bus.out_err), 64'd1);
        wait_drain();

        // Backpressure with a pending digit that must not be taken during HOLD
        bus.out_ready = 1'b0;
        codes = '{4'b0101, 4'b0110, 4'b0111, 4'b1000};
        send_word(codes, 4, 1'b0);
        snap_bcd  = bus.out_bcd;
        snap_mask = bus.out_err_mask;
        snap_cnt  = bus.out_count;
        check_eq("bp_bcd", 64'(snap_bcd), 64'h2345);
        bus.in_valid = 1'b1;
        bus.in_digit = 4'b1100;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check_eq("bp_stable", 64'({bus.out_valid, bus.out_count, bus.out_err_mask, bus.out_bcd}),
                     64'({1'b1, snap_cnt, snap_mask, snap_bcd}));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check_eq("bp_release_valid", 64'(bus.out_valid), 64'd0);
        check_eq("bp_release_ready", 64'(bus.in_ready), 64'd1);
        check_eq("bp_release_state", 64'(state_dbg), 64'(IDLE));
        check_eq("bp_release_cleared", 64'({bus.out_count, bus.out_bcd}), 64'd0);
        wait_drain();

        // Reset mid-word
        send_digit(4'b1100, 1'b0);
        send_digit(4'b1011, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("midrst_state", 64'(state_dbg), 64'(IDLE));
        check_eq("midrst_cleared", 64'({bus.out_count, bus.out_err_mask, bus.out_bcd}), 64'd0);
        codes = '{4'b0110, 4'b0110, 4'b0110, 4'b0110};
        send_word(codes, 4, 1'b0);
        check_eq("midrst_bcd", 64'(bus.out_bcd), 64'h3333);
        wait_drain();

        // in_last without in_valid is ignored
        codes = '{4'b0100, 4'b0101, 4'b0000, 4'b0000};
        exp_q.push_back(model_word(codes, 2));
        send_digit(codes[0], 1'b0);
        bus.in_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.in_last = 1'b0;
        check_eq("last_no_valid_state", 64'(state_dbg), 64'(COLLECT));
        send_digit(codes[1], 1'b1);
        check_eq("last_no_valid_bcd", 64'(bus.out_bcd), 64'h0012);
        wait_drain();

        // Every code as a single-digit word
        for (int c = 0; c < 16; c++) begin
            codes = '{4'(c), 4'b0000, 4'b0000, 4'b0000};
            send_word(codes, 1, 1'b1);
            check_eq("sweep_err", 64'(bus.out_err), 64'((c < 3 || c > 12) ? 1 : 0));
            check_eq("sweep_bcd", 64'(bus.out_bcd), 64'((c < 3 || c > 12) ? 0 : c - 3));
        end
        wait_drain();

        // Random words under random backpressure
        bp_mode = 1'b1;
        for (int w = 0; w < 40; w++) begin
            len = $urandom_range(1, NDIG);
            for (int i = 0; i < NDIG; i++) codes[i] = 4'($urandom_range(0, 15));
            send_word(codes, len, (len < NDIG) ? 1'b1 : 1'($urandom_range(0, 1)));
        end
        bp_mode = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_drain();
        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
